// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit that drives the register file write port.
// A multiply does one shift-add step per cycle and a divide does one restoring
// shift-subtract step per cycle, each on operand magnitudes. The sign is
// applied once, when the result is formed. Divide by zero and signed overflow
// skip the iteration and finish in the cycle after the accept.
module muldiv_unit #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [2:0]            funct3,
    input  logic [XLEN-1:0]       operand_a,
    input  logic [XLEN-1:0]       operand_b,
    input  logic [REG_ADDR_W-1:0] rd,
    output logic                  busy,
    output logic                  done,
    output logic [REG_ADDR_W-1:0] write_address,
    output logic [XLEN-1:0]       write_data,
    output logic                  write_enable
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

    state_t                  state, state_next;
    logic [CNT_W-1:0]        counter;
    logic [2:0]              funct3_q;
    logic [REG_ADDR_W-1:0]   rd_q;
    logic                    neg_q, rneg_q;
    logic [XLEN-1:0]         acc_hi, acc_lo, opnd;

    logic                    is_div, a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]         a_mag, b_mag;
    logic                    div_by_zero, div_ovf, special;
    logic [XLEN-1:0]         special_result;

    logic [XLEN:0]           mul_sum, div_shift, div_diff;
    logic                    div_ok;
    logic [2*XLEN-1:0]       prod_next, prod_signed;
    logic [XLEN-1:0]         rem_next, quo_next, rem_signed, quo_signed, calc_result;

    logic                    done_d, we_d, busy_d;
    logic [REG_ADDR_W-1:0]   wa_d;
    logic [XLEN-1:0]         wd_d;

    // Operand decode at the accept point: signedness, magnitudes, special divides
    always_comb begin
        is_div      = funct3[2];
        a_signed    = is_div ? !funct3[0] : (funct3[1:0] != 2'b11);
        b_signed    = is_div ? !funct3[0] : !funct3[1];
        a_neg       = a_signed & operand_a[XLEN-1];
        b_neg       = b_signed & operand_b[XLEN-1];
        a_mag       = a_neg ? -operand_a : operand_a;
        b_mag       = b_neg ? -operand_b : operand_b;
        div_by_zero = is_div && (operand_b == '0);
        div_ovf     = is_div && !funct3[0] && (operand_a == INT_MIN) && (operand_b == '1);
        special     = div_by_zero || div_ovf;
        if (div_by_zero)
            special_result = funct3[1] ? operand_a : '1;
        else
            special_result = funct3[1] ? '0 : INT_MIN;
    end

    // One iteration step for both datapaths, plus the signed result of the final step
    always_comb begin
        mul_sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        prod_next   = {mul_sum, acc_lo[XLEN-1:1]};
        div_shift   = {acc_hi, acc_lo[XLEN-1]};
        div_diff    = div_shift - {1'b0, opnd};
        div_ok      = !div_diff[XLEN];
        rem_next    = div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
        quo_next    = {acc_lo[XLEN-2:0], div_ok};
        prod_signed = neg_q ? -prod_next : prod_next;
        quo_signed  = neg_q ? -quo_next : quo_next;
        rem_signed  = rneg_q ? -rem_next : rem_next;
        if (!funct3_q[2])
            calc_result = (funct3_q[1:0] == 2'b00) ? prod_signed[XLEN-1:0]
                                                    : prod_signed[2*XLEN-1:XLEN];
        else
            calc_result = funct3_q[1] ? rem_signed : quo_signed;
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = special ? DONE : CALC;
            CALC:    if (counter == LAST_STEP) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        busy_d = (state_next != IDLE);
        done_d = 1'b0;
        we_d   = 1'b0;
        wa_d   = write_address;
        wd_d   = write_data;
        case (state)
            IDLE: if (start && special) begin
                done_d = 1'b1;
                we_d   = (rd != '0);
                wa_d   = rd;
                wd_d   = special_result;
            end
            CALC: if (counter == LAST_STEP) begin
                done_d = 1'b1;
                we_d   = (rd_q != '0);
                wa_d   = rd_q;
                wd_d   = calc_result;
            end
            default: ;
        endcase
    end

    // Registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy          <= 1'b0;
            done          <= 1'b0;
            write_enable  <= 1'b0;
            write_address <= '0;
            write_data    <= '0;
        end else begin
            busy          <= busy_d;
            done          <= done_d;
            write_enable  <= we_d;
            write_address <= wa_d;
            write_data    <= wd_d;
        end
    end

    // Operand latch on accept, then one iteration per CALC cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counter  <= '0;
            funct3_q <= '0;
            rd_q     <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
        end else if (state == IDLE) begin
            if (start && !special) begin
                counter  <= '0;
                funct3_q <= funct3;
                rd_q     <= rd;
                neg_q    <= a_neg ^ b_neg;
                rneg_q   <= a_neg;
                acc_hi   <= '0;
                acc_lo   <= is_div ? a_mag : b_mag;
                opnd     <= is_div ? b_mag : a_mag;
            end
        end else if (state == CALC) begin
            counter <= counter + 1'b1;
            if (!funct3_q[2]) begin
                {acc_hi, acc_lo} <= prod_next;
            end else begin
                acc_hi <= rem_next;
                acc_lo <= quo_next;
            end
        end
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide execution unit on the register file write port. Consumes rs1/rs2 operand values read from the register file plus the decoded funct3/rd, computes one M-extension result over multiple cycles, and drives write_address/write_data/write_enable directly into the register file write port. The core stalls issue while busy is high.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN
REG_ADDR_W, 5, destination register address width

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
start  input  1  request; sampled only in IDLE
funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
operand_a  input  XLEN  rs1 value (multiplicand / dividend)
operand_b  input  XLEN  rs2 value (multiplier / divisor)
rd  input  REG_ADDR_W  destination register
busy  output  1  high in CALC and DONE
done  output  1  one-cycle completion pulse
write_address  output  REG_ADDR_W  to register file write_address
write_data  output  XLEN  to register file write_data
write_enable  output  1  to register file write_enable

Behaviour:
- Reset (async, reset_n low): state IDLE; busy, done, write_enable = 0; write_address, write_data, counter and internal accumulators = 0. Reset during CALC/DONE aborts the operation; no write is issued.
- States: IDLE, CALC, DONE.
- IDLE: start=1 at a rising edge latches funct3, rd, and operands (sign-handled per op) -> CALC with counter=0. Special divide cases go directly to DONE instead (see below). start=0 keeps IDLE.
- CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle on magnitudes. Counter increments each cycle. After XLEN cycles -> DONE.
- DONE (exactly 1 cycle): done=1; write_enable=1 iff latched rd != 0; write_address=latched rd; write_data=result. Next edge -> IDLE.
- Latency: normal ops assert done/write_enable in the cycle after XLEN+1 edges following the accept edge (33rd cycle for XLEN=32). Special cases assert it in the cycle immediately after the accept edge.
- Outputs are registered. write_data/write_address hold their last value outside DONE. write_enable and done are 0 outside DONE.
- start while busy (CALC or DONE) is ignored, with no queuing. Operand/funct3/rd changes after accept have no effect.
- Multiply: 2*XLEN-bit product. MUL returns the low XLEN bits. MULH/MULHSU/MULHU return the high XLEN bits with signed*signed, signed*unsigned, and unsigned*unsigned operands respectively. Signed ops multiply magnitudes and negate the 2*XLEN product when exactly one signed operand is negative.
- Divide: signed ops divide magnitudes. The quotient is negated if the operand signs differ. The remainder takes the dividend's sign (truncating division).
- Divisor == 0 (special): DIV/DIVU quotient = all ones; REM/REMU remainder = operand_a.
- Signed overflow (special, DIV/REM only): operand_a = 0x80000000 and operand_b = 0xFFFFFFFF gives quotient 0x80000000 and remainder 0.
- rd == 0: the full operation still runs and done pulses, but write_enable stays 0.

Test Plan:
- MUL, a=7, b=0xFFFFFFFD (-3), rd=5 -> 33rd cycle after accept: write_enable=1, write_address=5, write_data=0xFFFFFFEB, done=1 for exactly one cycle; busy high from the cycle after accept through DONE.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF(-1)*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9(-7)/2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Special cases, each with write_enable in the first cycle after accept: DIV x/0 -> 0xFFFFFFFF. REMU 0x1234/0 -> 0x1234. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM same operands -> 0.
- start held high and operands changed during CALC -> exactly one write with the originally latched result. A start in the DONE cycle is not accepted, and the next accept occurs only after return to IDLE.
- reset_n pulsed low at cycle 10 of CALC -> outputs 0 immediately with no write_enable pulse, then a new MUL 3*4 after release -> write_data=12. rd=0 MUL 3*4 -> done pulses, write_enable stays 0.
